tok_table_ctrl: RTL and testbench
=================================

# tok_table_ctrl

Sequencer and two-port arbiter for the TOK symbol table (16-bit key RAM and 16-bit value RAM, linear probing, key 0 = empty slot). It accepts lookup and insert requests from two requesters (port 0: core, port 1: UART loader/debug host), arbitrates round-robin, and drives the synchronous-read table RAMs one probe per cycle. It returns hit/miss/full status and the read value on a shared response bus.

## Interface
- TABLE_WIDTH, 8: table address width; 2^TABLE_WIDTH slots.
- KEY_WIDTH, 16: key and value width.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  2  per-port request; held until granted.
- op0, op1  in  2  op per port: 00 lookup, 01 insert, 10 clear, 11 reserved.
- key0, key1  in  KEY_WIDTH  per-port key.
- wval0, wval1  in  KEY_WIDTH  per-port insert value.
- gnt  out  2  one-hot, one-cycle grant pulse; the request is latched on that cycle.
- busy  out  1  high from the grant cycle until the cycle after rsp_valid.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  port that owns the response.
- rsp_hit  out  1  lookup found the key; insert wrote the slot.
- rsp_err  out  1  full, key 0, reserved op, or clear while compiled out.
- rsp_val  out  KEY_WIDTH  value read on a lookup hit, else 0.
- tbl_raddr  out  TABLE_WIDTH  read address to both RAMs; data returns next cycle.
- tbl_key_rd, tbl_val_rd  in  KEY_WIDTH  RAM read data.
- tbl_we  out  1  write strobe to both RAMs.
- tbl_waddr  out  TABLE_WIDTH  write address.
- tbl_key_wd, tbl_val_wd  out  KEY_WIDTH  write data.

## Operation
- States: IDLE, PROBE, CLEAR, RESP.
- IDLE:
  - The arbiter grants if any req is high.
  - On a grant, latch op, key, val and id; set idx = key[TABLE_WIDTH-1:0] and count = 0.
  - Drive tbl_raddr = idx, then go to PROBE.
- Key 0, or op 11, goes straight to RESP with rsp_err=1. No RAM access occurs.
- Arbitration: round-robin with a last-granted pointer.
  - When both ports request, the port not granted last wins.
  - After reset, port 0 wins the first tie.
- PROBE, lookup:
  - tbl_key_rd == key: hit. rsp_val = tbl_val_rd; go to RESP.
  - tbl_key_rd == 0: miss. Go to RESP with hit=0, err=0.
  - Otherwise: advance one slot.
- PROBE, insert:
  - tbl_key_rd == key or tbl_key_rd == 0: assert tbl_we for one cycle at idx with key/val. Go to RESP with hit=1.
  - Otherwise: advance one slot.
- Advance: idx = idx+1, wrapping modulo 2^TABLE_WIDTH; count = count+1; tbl_raddr = new idx.
  - If count reaches 2^TABLE_WIDTH−1 before a match, go to RESP with err=1 (table full / exhausted).
  - No slot is probed twice.
- RESP: rsp_valid=1 for one cycle, then return to IDLE. No grant is issued in RESP.
- Outputs hold their last value except for the strobes rsp_valid, gnt and tbl_we.

## Timing
- Reset values: gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_hit=0, rsp_err=0, rsp_val=0, tbl_we=0, tbl_raddr=0, tbl_waddr=0, write data=0, state IDLE, arbiter pointer → port 0.
- Latency, grant at cycle 0:
  - Home-slot result is evaluated in cycle 1; rsp_valid in cycle 2.
  - Each extra probe adds 1 cycle.
  - Key-0 or reserved op: rsp_valid in cycle 1.
- Insert write: tbl_we is in the same cycle as the deciding PROBE. A request granted immediately afterwards sees the written data.
- Back-to-back requests: the next grant comes no earlier than the cycle after rsp_valid.
- Reset while not IDLE: next cycle is IDLE. No rsp_valid, no tbl_we, table contents unchanged.
- A req dropped before its grant is simply not served. A req held through busy is not re-granted early.

## Configuration
- TOK_TABLE_CLEAR_EN defined:
  - op 10 enters CLEAR and writes key=0, val=0 to slots 0 … 2^TABLE_WIDTH−1, one per cycle.
  - Then RESP with hit=1, err=0.
  - Latency: 2^TABLE_WIDTH+1 cycles from grant to rsp_valid.
- Undefined: op 10 behaves as reserved. rsp_err=1 in cycle 1, no writes. The CLEAR state and its counter are absent.

## Structure
- Shared package tok_table_pkg: op encodings, state enum, default TABLE_WIDTH and KEY_WIDTH.
- One sub-module: tok_rr_arb, the 2-way round-robin arbiter (req → one-hot gnt, pointer update on grant).

## Test plan
- Port 0: insert key 0x1234, val 0xBEEF into empty table, then lookup 0x1234 → both rsp_hit=1; lookup rsp_val=0xBEEF in cycle 2.
- Insert 0x0105 then 0x0205 (both home slot 0x05) → second write lands at slot 0x06. Lookup 0x0205 responds one cycle later than lookup 0x0105.
- Both ports request every cycle → grants alternate 0,1,0,1; the first tie after reset goes to port 0.
- Fill all 256 slots, then insert a new key → rsp_err=1 after 256 probes. Lookup of an absent key on the full table → rsp_err=1.
- Lookup key 0 → rsp_err=1 in cycle 1, tbl_we never asserted.
- Assert reset mid-probe → no response, no write; a following lookup of the old key still hits.
- With TOK_TABLE_CLEAR_EN, clear after fills → all lookups miss. Without it, op 10 → rsp_err=1.

Source files
------------

// File: rtl/tok_table_pkg.sv
// Shared definitions for the TOK symbol-table controller: op encodings,
// FSM state enum and default table/key widths.
package tok_table_pkg;

  localparam int unsigned TABLE_WIDTH_DEF = 8;
  localparam int unsigned KEY_WIDTH_DEF   = 16;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } tok_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_CLEAR,
    ST_RESP
  } tok_state_e;

endpackage

// File: rtl/tok_table_ctrl_arb.sv
// tok_rr_arb: two-way round-robin arbiter; combinational one-hot grant,
// tie priority flips to the other port after every grant.
module tok_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;  // port that wins the next tie

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)      prio_q <= 1'b0;
    else if (|gnt)   prio_q <= gnt[0];
  end

endmodule

// File: rtl/tok_table_ctrl.sv
// TOK symbol-table sequencer: arbitrates two requesters and runs linear-probe
// lookup/insert on sync-read key/value RAMs. Optional clear: TOK_TABLE_CLEAR_EN.
module tok_table_ctrl
  import tok_table_pkg::*;
#(
  parameter int unsigned TABLE_WIDTH = TABLE_WIDTH_DEF,
  parameter int unsigned KEY_WIDTH   = KEY_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [1:0]             op0,
  input  logic [1:0]             op1,
  input  logic [KEY_WIDTH-1:0]   key0,
  input  logic [KEY_WIDTH-1:0]   key1,
  input  logic [KEY_WIDTH-1:0]   wval0,
  input  logic [KEY_WIDTH-1:0]   wval1,
  output logic [1:0]             gnt,
  output logic                   busy,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic                   rsp_hit,
  output logic                   rsp_err,
  output logic [KEY_WIDTH-1:0]   rsp_val,
  output logic [TABLE_WIDTH-1:0] tbl_raddr,
  input  logic [KEY_WIDTH-1:0]   tbl_key_rd,
  input  logic [KEY_WIDTH-1:0]   tbl_val_rd,
  output logic                   tbl_we,
  output logic [TABLE_WIDTH-1:0] tbl_waddr,
  output logic [KEY_WIDTH-1:0]   tbl_key_wd,
  output logic [KEY_WIDTH-1:0]   tbl_val_wd
);

  tok_state_e             state_q, state_d;
  tok_op_e                op_q, op_g;
  logic [KEY_WIDTH-1:0]   key_q, val_q, key_g, val_g;
  logic                   id_q, id_g, id_d;
  logic [TABLE_WIDTH-1:0] idx_q, cnt_q, raddr_q, waddr_q;
  logic [KEY_WIDTH-1:0]   kwd_q, vwd_q;
  logic                   arb_en, granted;
  logic                   key_match, slot_empty, exhausted, probe_done, probe_wr;
  logic                   rsp_set, hit_d, err_d;
  logic [KEY_WIDTH-1:0]   val_d;
`ifdef TOK_TABLE_CLEAR_EN
  logic [TABLE_WIDTH-1:0] clr_q;
`endif

  assign arb_en = reset && (state_q == ST_IDLE);

  tok_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req),
    .gnt   (gnt)
  );

  assign granted = |gnt;
  assign id_g    = gnt[1];
  assign op_g    = tok_op_e'(gnt[1] ? op1 : op0);
  assign key_g   = gnt[1] ? key1  : key0;
  assign val_g   = gnt[1] ? wval1 : wval0;

  assign key_match  = (tbl_key_rd == key_q);
  assign slot_empty = (tbl_key_rd == '0);
  assign exhausted  = (cnt_q == '1);
  assign probe_done = key_match || slot_empty || exhausted;
  assign probe_wr   = (op_q == OP_INSERT) && (key_match || slot_empty);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rsp_set = 1'b0;
    hit_d   = 1'b0;
    err_d   = 1'b0;
    val_d   = '0;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: if (granted) begin
        id_d = id_g;
        case (op_g)
          OP_LOOKUP, OP_INSERT: begin
            if (key_g == '0) begin
              state_d = ST_RESP;
              rsp_set = 1'b1;
              err_d   = 1'b1;
            end else begin
              state_d = ST_PROBE;
            end
          end
`ifdef TOK_TABLE_CLEAR_EN
          OP_CLEAR: state_d = ST_CLEAR;
`endif
          default: begin
            state_d = ST_RESP;
            rsp_set = 1'b1;
            err_d   = 1'b1;
          end
        endcase
      end
      ST_PROBE: if (probe_done) begin
        state_d = ST_RESP;
        rsp_set = 1'b1;
        if (op_q == OP_INSERT) begin
          hit_d = key_match || slot_empty;
          err_d = !(key_match || slot_empty);
        end else begin
          hit_d = key_match;
          err_d = !key_match && !slot_empty;
          val_d = key_match ? tbl_val_rd : '0;
        end
      end
      ST_CLEAR: begin
`ifdef TOK_TABLE_CLEAR_EN
        if (clr_q == '1) begin
          state_d = ST_RESP;
          rsp_set = 1'b1;
          hit_d   = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/data outputs are combinational so the RAM sees them in the deciding
  // cycle; the *_q copies keep them steady between accesses.
  always_comb begin
    rsp_valid  = reset && (state_q == ST_RESP);
    busy       = granted || (state_q != ST_IDLE);
    tbl_we     = 1'b0;
    tbl_raddr  = raddr_q;
    tbl_waddr  = waddr_q;
    tbl_key_wd = kwd_q;
    tbl_val_wd = vwd_q;
    case (state_q)
      ST_IDLE: if (granted && (state_d == ST_PROBE)) tbl_raddr = key_g[TABLE_WIDTH-1:0];
      ST_PROBE: begin
        if (probe_wr) begin
          tbl_we     = reset;
          tbl_waddr  = idx_q;
          tbl_key_wd = key_q;
          tbl_val_wd = val_q;
        end else if (!probe_done) begin
          tbl_raddr = idx_q + 1'b1;
        end
      end
`ifdef TOK_TABLE_CLEAR_EN
      ST_CLEAR: begin
        tbl_we     = reset;
        tbl_waddr  = clr_q;
        tbl_key_wd = '0;
        tbl_val_wd = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q    <= OP_LOOKUP;
      key_q   <= '0;
      val_q   <= '0;
      id_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      kwd_q   <= '0;
      vwd_q   <= '0;
      rsp_id  <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_err <= 1'b0;
      rsp_val <= '0;
    end else begin
      raddr_q <= tbl_raddr;
      waddr_q <= tbl_waddr;
      kwd_q   <= tbl_key_wd;
      vwd_q   <= tbl_val_wd;
      if (granted) begin
        op_q  <= op_g;
        key_q <= key_g;
        val_q <= val_g;
        id_q  <= id_g;
        idx_q <= key_g[TABLE_WIDTH-1:0];
        cnt_q <= '0;
      end else if ((state_q == ST_PROBE) && !probe_done) begin
        idx_q <= idx_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
      if (rsp_set) begin
        rsp_id  <= id_d;
        rsp_hit <= hit_d;
        rsp_err <= err_d;
        rsp_val <= val_d;
      end
    end
  end

`ifdef TOK_TABLE_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!reset)                  clr_q <= '0;
    else if (state_q == ST_CLEAR) clr_q <= clr_q + 1'b1;
    else                         clr_q <= '0;
  end
`endif

endmodule

// File: tb/tb_tok_table_ctrl.sv
// Directed bench for tok_table_ctrl with a behavioural sync-read key/value RAM.
module tb_tok_table_ctrl;

  localparam int unsigned TW = 8;
  localparam int unsigned KW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    op0, op1;
  logic [KW-1:0] key0, key1, wval0, wval1;
  logic [1:0]    gnt;
  logic          busy, rsp_valid, rsp_id, rsp_hit, rsp_err;
  logic [KW-1:0] rsp_val;
  logic [TW-1:0] tbl_raddr, tbl_waddr;
  logic [KW-1:0] tbl_key_rd, tbl_val_rd, tbl_key_wd, tbl_val_wd;
  logic          tbl_we;

  logic [KW-1:0] kmem [256];
  logic [KW-1:0] vmem [256];
  logic          wipe;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int rv_cnt   = 0;

  logic          r_hit, r_err, r_id;
  logic [KW-1:0] r_val;
  int            r_lat, we0, rv0, n_ok, ng;
  int            gseq [4];
  int            gcyc [4];

  always #5 clk = ~clk;

  tok_table_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op0        (op0),
    .op1        (op1),
    .key0       (key0),
    .key1       (key1),
    .wval0      (wval0),
    .wval1      (wval1),
    .gnt        (gnt),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_hit    (rsp_hit),
    .rsp_err    (rsp_err),
    .rsp_val    (rsp_val),
    .tbl_raddr  (tbl_raddr),
    .tbl_key_rd (tbl_key_rd),
    .tbl_val_rd (tbl_val_rd),
    .tbl_we     (tbl_we),
    .tbl_waddr  (tbl_waddr),
    .tbl_key_wd (tbl_key_wd),
    .tbl_val_wd (tbl_val_wd)
  );

  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 256; i++) begin
        kmem[i] <= '0;
        vmem[i] <= '0;
      end
    end else if (tbl_we) begin
      kmem[tbl_waddr] <= tbl_key_wd;
      vmem[tbl_waddr] <= tbl_val_wd;
    end
    tbl_key_rd <= kmem[tbl_raddr];
    tbl_val_rd <= vmem[tbl_raddr];
  end

  always @(negedge clk) begin
    if (tbl_we)    we_cnt++;
    if (rsp_valid) rv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Issues one request and waits for its response; lat = cycles from grant to
  // rsp_valid, or -1 if no grant or response arrived within the bound.
  task automatic run_op(input int port, input logic [1:0] op, input logic [KW-1:0] key,
                        input logic [KW-1:0] val, output logic hit, output logic err,
                        output logic [KW-1:0] rv, output logic id, output int lat);
    bit granted = 0;
    lat = -1; hit = 1'b0; err = 1'b0; rv = '0; id = 1'b0;
    @(negedge clk);
    if (port == 0) begin op0 = op; key0 = key; wval0 = val; end
    else           begin op1 = op; key1 = key; wval1 = val; end
    req[port] = 1'b1;
    for (int c = 0; c < 8 && !granted; c++) begin
      #1;
      if (gnt[port]) granted = 1;
      else @(negedge clk);
    end
    if (!granted) begin
      req[port] = 1'b0;
      return;
    end
    @(negedge clk);
    req[port] = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (rsp_valid) begin
        lat = c; hit = rsp_hit; err = rsp_err; rv = rsp_val; id = rsp_id;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; wipe = 1'b1; req = '0;
    op0 = '0; op1 = '0; key0 = '0; key1 = '0; wval0 = '0; wval1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1; wipe = 1'b0;
    @(negedge clk);
    check("rst_gnt",   gnt, 0);
    check("rst_busy",  busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_flags", {rsp_id, rsp_hit, rsp_err}, 0);
    check("rst_val",   rsp_val, 0);
    check("rst_we",    tbl_we, 0);
    check("rst_addr",  {tbl_raddr, tbl_waddr}, 0);
    check("rst_wd",    {tbl_key_wd, tbl_val_wd}, 0);

    run_op(0, 2'b01, 16'h1234, 16'hBEEF, r_hit, r_err, r_val, r_id, r_lat);
    check("ins1_hit", {r_hit, r_err, r_id}, 3'b100);
    check("ins1_lat", r_lat, 2);
    check("ins1_mem", {kmem[8'h34], vmem[8'h34]}, 32'h1234BEEF);
    @(negedge clk);
    check("busy_after", busy, 0);

    run_op(0, 2'b00, 16'h1234, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("lk1_hit", {r_hit, r_err}, 2'b10);
    check("lk1_val", r_val, 16'hBEEF);
    check("lk1_lat", r_lat, 2);

    run_op(0, 2'b01, 16'h0105, 16'h1111, r_hit, r_err, r_val, r_id, r_lat);
    check("ins105_lat", r_lat, 2);
    run_op(1, 2'b01, 16'h0205, 16'h2222, r_hit, r_err, r_val, r_id, r_lat);
    check("ins205_hit", {r_hit, r_err, r_id}, 3'b101);
    check("ins205_lat", r_lat, 3);
    check("ins205_mem", kmem[8'h06], 16'h0205);
    run_op(0, 2'b00, 16'h0105, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("lk105", {r_hit, r_err, r_val, 8'(r_lat)}, {2'b10, 16'h1111, 8'd2});
    run_op(1, 2'b00, 16'h0205, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("lk205", {r_hit, r_err, r_val, 8'(r_lat)}, {2'b10, 16'h2222, 8'd3});

    run_op(0, 2'b01, 16'h01FF, 16'h3333, r_hit, r_err, r_val, r_id, r_lat);
    run_op(0, 2'b01, 16'h02FF, 16'h4444, r_hit, r_err, r_val, r_id, r_lat);
    check("wrap_mem", kmem[8'h00], 16'h02FF);
    run_op(0, 2'b00, 16'h02FF, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("wrap_lk", {r_hit, r_err, r_val, 8'(r_lat)}, {2'b10, 16'h4444, 8'd3});

    run_op(1, 2'b00, 16'h0777, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("miss", {r_hit, r_err, r_val, 8'(r_lat)}, {2'b00, 16'h0000, 8'd2});

    we0 = we_cnt;
    run_op(0, 2'b00, 16'h0000, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("key0", {r_hit, r_err, 8'(r_lat)}, {2'b01, 8'd1});
    run_op(1, 2'b11, 16'h1234, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("rsvd", {r_hit, r_err, r_id, 8'(r_lat)}, {3'b011, 8'd1});
    check("key0_rsvd_nowe", we_cnt - we0, 0);

`ifndef TOK_TABLE_CLEAR_EN
    we0 = we_cnt;
    run_op(0, 2'b10, 16'h1234, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("clr_off", {r_hit, r_err, 8'(r_lat)}, {2'b01, 8'd1});
    check("clr_off_nowe", we_cnt - we0, 0);
`endif

    // Round-robin: both ports request continuously right after reset.
    apply_reset();
    @(negedge clk);
    op0 = 2'b00; key0 = 16'h1234; op1 = 2'b00; key1 = 16'h0777; req = 2'b11;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (gnt != 2'b00) begin
        gseq[ng] = int'(gnt[1]);
        gcyc[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    req = '0;
    repeat (4) @(negedge clk);
    check("rr_count", ng, 4);
    check("rr_seq", {gseq[0][0], gseq[1][0], gseq[2][0], gseq[3][0]}, 4'b0101);
    check("rr_gap", {8'(gcyc[1] - gcyc[0]), 8'(gcyc[2] - gcyc[1]), 8'(gcyc[3] - gcyc[2])},
          {8'd3, 8'd3, 8'd3});

    // Reset while the insert of 0x0405 is probing slot 6.
    we0 = we_cnt; rv0 = rv_cnt;
    @(negedge clk);
    op0 = 2'b01; key0 = 16'h0405; wval0 = 16'h5555; req = 2'b01;
    #1;
    check("mr_gnt", {gnt, busy}, 3'b011);
    @(negedge clk); req = '0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    check("mr_nowe", we_cnt - we0, 0);
    check("mr_norsp", rv_cnt - rv0, 0);
    check("mr_idle", busy, 0);
    run_op(0, 2'b00, 16'h0205, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("mr_old", {r_hit, r_err, r_val}, {2'b10, 16'h2222});
    run_op(0, 2'b00, 16'h0405, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("mr_new", {r_hit, r_err, 8'(r_lat)}, {2'b00, 8'd4});

    // Fill an empty table with one key per home slot, then probe it full.
    @(negedge clk); wipe = 1'b1;
    @(negedge clk); wipe = 1'b0;
    n_ok = 0;
    for (int i = 0; i < 256; i++) begin
      run_op(i % 2, 2'b01, 16'h0100 | 16'(i), 16'hA000 | 16'(i), r_hit, r_err, r_val, r_id, r_lat);
      if (r_lat < 0) break;
      if (r_hit && !r_err && r_lat == 2) n_ok++;
    end
    check("fill_ok", n_ok, 256);
    we0 = we_cnt;
    run_op(0, 2'b01, 16'h0999, 16'h9999, r_hit, r_err, r_val, r_id, r_lat);
    check("full_ins", {r_hit, r_err, 16'(r_lat)}, {2'b01, 16'd257});
    check("full_nowe", we_cnt - we0, 0);
    run_op(1, 2'b00, 16'h0888, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("full_lk", {r_hit, r_err, r_val, 16'(r_lat)}, {2'b01, 16'h0000, 16'd257});
    run_op(0, 2'b00, 16'h01FF, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("full_hit", {r_hit, r_err, r_val, 8'(r_lat)}, {2'b10, 16'hA0FF, 8'd2});

`ifdef TOK_TABLE_CLEAR_EN
    we0 = we_cnt;
    run_op(1, 2'b10, 16'h0001, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("clr_rsp", {r_hit, r_err, 16'(r_lat)}, {2'b10, 16'd257});
    check("clr_we", we_cnt - we0, 256);
    run_op(0, 2'b00, 16'h0142, 16'h0, r_hit, r_err, r_val, r_id, r_lat);
    check("clr_miss", {r_hit, r_err, 8'(r_lat)}, {2'b00, 8'd2});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
